// File: rtl/tone_env_pkg.sv
// Shared definitions for the tone envelope stage: state encoding, field widths
// and the release-step helper.
// Build option: TONE_ENV_EXP_RELEASE_EN selects an exponential-style release
// (subtract max(1, level>>2)) instead of a linear decrement by one.
package tone_env_pkg;

    localparam int LEVEL_W = 4;
    localparam int RATE_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } envState_t;

    // Next level for one release step; saturates at zero.
    function automatic logic [LEVEL_W-1:0] releaseStep(input logic [LEVEL_W-1:0] lvl);
        logic [LEVEL_W-1:0] dec;
`ifdef TONE_ENV_EXP_RELEASE_EN
        dec = lvl >> 2;
        if (dec == '0) dec = LEVEL_W'(1);
`else
        dec = LEVEL_W'(1);
`endif
        return (lvl > dec) ? (lvl - dec) : '0;
    endfunction

endpackage

// File: rtl/tone_env_scale.sv
// Combinational 4x4 unsigned multiply returning the upper nibble of the
// product, i.e. sample * level / 16 rounded down.
module tone_env_scale
    import tone_env_pkg::*;
(
    input  logic [LEVEL_W-1:0] sample,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] scaled
);

    // Zero-extend both operands so the full 8-bit product is formed before the shift.
    assign scaled = LEVEL_W'(({{LEVEL_W{1'b0}}, sample} * {{LEVEL_W{1'b0}}, level}) >> LEVEL_W);

endmodule

// File: rtl/tone_envelope.sv
// Volume/envelope stage behind the tone generator: an attack/hold/release
// envelope gated by KEY scales the incoming sample.
// Build option: TONE_ENV_EXP_RELEASE_EN (see tone_env_pkg) changes the release slope.
//
//  state   | meaning
//  IDLE    | no note, LEVEL parked at 0
//  ATTACK  | LEVEL climbs one per step until it reaches VOL
//  HOLD    | LEVEL tracks VOL one step at a time
//  RELEASE | LEVEL falls per step; reaching 0 returns to IDLE
module tone_envelope
    import tone_env_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic               CLK,
    input  logic               RST_C,
    input  logic [LEVEL_W-1:0] DIN,
    input  logic               VSEL,
    input  logic               RSEL,
    input  logic               KEY,
    input  logic               ENV_TICK,
    input  logic [LEVEL_W-1:0] SIN,
    output logic [LEVEL_W-1:0] DOUT,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               BUSY
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [LEVEL_W-1:0] volQ;
    logic [RATE_W-1:0]  rateQ;
    logic [PRESC_W-1:0] prescQ;
    logic [RATE_W-1:0]  rateCntQ;
    logic               keyQ;
    logic [LEVEL_W-1:0] levelQ;
    logic [LEVEL_W-1:0] levelNext;
    logic [LEVEL_W-1:0] doutQ;
    logic [LEVEL_W-1:0] scaledSample;
    envState_t          stateQ;
    envState_t          stateNext;

    logic keyRise;
    logic keyFall;
    logic keyEdge;
    logic prescWrap;
    logic step;

    assign keyRise   = KEY & ~keyQ;
    assign keyFall   = ~KEY & keyQ;
    assign keyEdge   = keyRise | keyFall;
    assign prescWrap = ENV_TICK && (prescQ == PRESC_LAST);
    // A key edge takes priority over a coincident step.
    assign step      = prescWrap && (rateCntQ == rateQ) && !keyEdge;

    // CPU-written volume and rate registers; both strobes may load together.
    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) begin
            volQ  <= '0;
            rateQ <= '0;
        end else begin
            if (VSEL) volQ  <= DIN;
            if (RSEL) rateQ <= DIN;
        end
    end

    // KEY history for edge detection; cleared by reset so a held key re-triggers.
    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) keyQ <= 1'b0;
        else       keyQ <= KEY;
    end

    // Prescaler and rate counter; any key edge restarts a full step period.
    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) begin
            prescQ   <= '0;
            rateCntQ <= '0;
        end else if (keyEdge) begin
            prescQ   <= '0;
            rateCntQ <= '0;
        end else if (ENV_TICK) begin
            prescQ <= prescWrap ? '0 : prescQ + 1'b1;
            if (prescWrap) rateCntQ <= (rateCntQ == rateQ) ? '0 : rateCntQ + 1'b1;
        end
    end

    // Envelope state and level registers.
    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) begin
            stateQ <= IDLE;
            levelQ <= '0;
        end else begin
            stateQ <= stateNext;
            levelQ <= levelNext;
        end
    end

    // Envelope next-state and level arithmetic.
    always_comb begin
        stateNext = stateQ;
        levelNext = levelQ;
        case (stateQ)
            IDLE: begin
                if (keyRise) stateNext = ATTACK;
            end
            ATTACK: begin
                if (keyFall) begin
                    stateNext = RELEASE;
                end else if (step) begin
                    // Already at or above target (e.g. VOL=0): settle in HOLD without a jump.
                    if (levelQ >= volQ) begin
                        stateNext = HOLD;
                    end else begin
                        levelNext = levelQ + 1'b1;
                        if (levelNext >= volQ) stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (keyFall) begin
                    stateNext = RELEASE;
                end else if (step) begin
                    if (levelQ < volQ)      levelNext = levelQ + 1'b1;
                    else if (levelQ > volQ) levelNext = levelQ - 1'b1;
                end
            end
            RELEASE: begin
                if (keyRise) begin
                    stateNext = ATTACK;
                end else if (step) begin
                    levelNext = releaseStep(levelQ);
                    if (levelNext == '0) stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                levelNext = '0;
            end
        endcase
    end

    tone_env_scale uScale (
        .sample (SIN),
        .level  (levelQ),
        .scaled (scaledSample)
    );

    // Registered output sample, one cycle behind SIN/LEVEL.
    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) doutQ <= '0;
        else       doutQ <= scaledSample;
    end

    assign DOUT  = doutQ;
    assign LEVEL = levelQ;
    assign BUSY  = (stateQ != IDLE);

endmodule
